keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, frame-based debounce, one strobe per press.
// Optional auto-repeat while a key stays held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1024,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LAST    = 4'(DEBOUNCE_FRAMES);
  localparam logic [15:0] RPT_LAST   = 16'(REPEAT_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  logic [3:0]  row_meta, row_sync;
  logic [15:0] dwell;
  logic [15:0] work_map, work_map_nxt, frame_map;
  logic        frame_done;
  logic        last_dwell, frame_end;
  logic [3:0]  col_nxt;
  logic [1:0]  col_idx;
  logic        col_legal;

  assign last_dwell = (dwell == DWELL_LAST);
  assign frame_end  = last_dwell && (col_out == 4'b1110);

  always_comb begin
    col_nxt   = 4'b0111;
    col_idx   = 2'd0;
    col_legal = 1'b1;
    case (col_out)
      4'b0111: begin col_nxt = 4'b1011; col_idx = 2'd3; end
      4'b1011: begin col_nxt = 4'b1101; col_idx = 2'd2; end
      4'b1101: begin col_nxt = 4'b1110; col_idx = 2'd1; end
      4'b1110: begin col_nxt = 4'b0111; col_idx = 2'd0; end
      default: col_legal = 1'b0;
    endcase
  end

  // Bit {row,col} of the map mirrors the key code layout.
  always_comb begin
    logic [3:0] idx;
    work_map_nxt = work_map;
    idx          = '0;
    if (last_dwell && col_legal) begin
      for (int unsigned r = 0; r < 4; r++) begin
        idx               = {r[1:0], col_idx};
        work_map_nxt[idx] = ~row_sync[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta   <= '1;
      row_sync   <= '1;
      dwell      <= '0;
      col_out    <= 4'b0111;
      work_map   <= '0;
      frame_map  <= '0;
      frame_done <= 1'b0;
    end else begin
      row_meta   <= row_in;
      row_sync   <= row_meta;
      work_map   <= work_map_nxt;
      frame_done <= frame_end;
      if (frame_end) frame_map <= work_map_nxt;
      if (last_dwell) begin
        dwell   <= '0;
        col_out <= col_nxt;
      end else begin
        dwell <= dwell + 16'd1;
      end
    end
  end

  logic [4:0] bits_set;
  logic [3:0] frame_key;
  logic       frame_none, frame_single;

  always_comb begin
    bits_set  = '0;
    frame_key = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_map[i]) begin
        bits_set  = bits_set + 5'd1;
        frame_key = 4'(i);
      end
    end
  end

  assign frame_none   = (frame_map == '0);
  assign frame_single = (bits_set == 5'd1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d, cnt_inc;
  logic [3:0]  cand, cand_d;
  logic [3:0]  code_d;
  logic        valid_d;
  logic [15:0] rpt, rpt_d, rpt_inc;

  assign cnt_inc  = cnt + 4'd1;
  assign rpt_inc  = rpt + 16'd1;
  assign key_held = (state == PRESSED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      rpt       <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      rpt       <= rpt_d;
    end
  end

  // MULTI frames neither start a press nor advance a release.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    code_d  = key_code;
    valid_d = 1'b0;
    rpt_d   = rpt;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_single) begin
            cand_d = frame_key;
            if (DB_LAST <= 4'd1) begin
              state_d = PRESSED;
              code_d  = frame_key;
              valid_d = 1'b1;
              cnt_d   = '0;
              rpt_d   = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_single && frame_key == cand) begin
            if (cnt_inc >= DB_LAST) begin
              state_d = PRESSED;
              code_d  = cand;
              valid_d = 1'b1;
              cnt_d   = '0;
              rpt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          if (frame_single && frame_key == cand) begin
            cnt_d = '0;
            if (AUTOREPEAT) begin
              if (rpt_inc >= RPT_LAST) begin
                valid_d = 1'b1;
                rpt_d   = '0;
              end else begin
                rpt_d = rpt_inc;
              end
            end
          end else if (frame_none) begin
            rpt_d = '0;
            if (cnt_inc >= DB_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
            rpt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: scan rotation, debounce, bounce, ghosting, reset, optional auto-repeat.
module tb_keypad_scanner;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB       = 3;
  localparam int unsigned RPT      = 2;

  logic        clk, rst_n;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, c0 = 0, base = 0;
  int strobe_cnt = 0, last_strobe_cyc = -1, dbl_cnt = 0;
  logic [3:0] last_code = '0;
  logic       prev_kv = 1'b0;
  logic [3:0] pats [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_FRAMES(DB),
    .REPEAT_FRAMES(RPT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  // Passive matrix: a row is pulled low when a pressed key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (key_valid) begin
      strobe_cnt++;
      last_code       = key_code;
      last_strobe_cyc = cyc;
      if (prev_kv) dbl_cnt++;
    end
    prev_kv = key_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] keys);
    rst_n   = 1'b0;
    pressed = keys;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    c0    = cyc;
  endtask

  task automatic wait_to(input int k);
    while (cyc - c0 < k) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col"},  32'(col_out),   32'h7);
    check_eq({tag, "_kv"},   32'(key_valid), 32'h0);
    check_eq({tag, "_code"}, 32'(key_code),  32'h0);
    check_eq({tag, "_held"}, 32'(key_held),  32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    pressed = '0;

    // Reset state and column rotation
    start_run(16'h0000);
    check_reset_outputs("t1_rst");
    release_rst();
    for (int k = 0; k <= 16; k++) begin
      check_eq($sformatf("t1_col%0d", k), 32'(col_out), 32'(pats[(k / 4) % 4]));
      @(negedge clk);
    end

    // Steady key at row 1, col 2 held from reset
    base = strobe_cnt;
    start_run(16'h0040);
    release_rst();
    wait_to(48);
    check_eq("t2_early", 32'(strobe_cnt - base), 32'd0);
    wait_to(60);
    check_eq("t2_count",   32'(strobe_cnt - base),      32'd1);
    check_eq("t2_latency", 32'(last_strobe_cyc - c0),   32'd49);
    check_eq("t2_code",    32'(last_code),              32'h6);
    check_eq("t2_outcode", 32'(key_code),               32'h6);
    check_eq("t2_held",    32'(key_held),               32'h1);
    pressed = 16'h0000;
    wait_to(112);
    check_eq("t2_held_pre", 32'(key_held), 32'h1);
    wait_to(113);
    check_eq("t2_held_drop", 32'(key_held), 32'h0);
    wait_to(160);
    check_eq("t2_no_extra", 32'(strobe_cnt - base), 32'd1);

    // Reset in DEBOUNCE with cnt=2, key kept pressed through reset
    base = strobe_cnt;
    start_run(16'h0020);
    check_eq("t5_rst_code", 32'(key_code), 32'h0);
    release_rst();
    wait_to(40);
    check_eq("t5_pre", 32'(strobe_cnt - base), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t5_mid");
    release_rst();
    wait_to(48);
    check_eq("t5_early", 32'(strobe_cnt - base), 32'd0);
    wait_to(60);
    check_eq("t5_count",   32'(strobe_cnt - base),    32'd1);
    check_eq("t5_latency", 32'(last_strobe_cyc - c0), 32'd49);
    check_eq("t5_code",    32'(last_code),            32'h5);

    // Bouncing key (row 2, col 1) toggling every 5 cycles for 4 frames
    base = strobe_cnt;
    start_run(16'h0000);
    release_rst();
    pressed = 16'h0200;
    for (int t = 5; t <= 60; t += 5) begin
      wait_to(t);
      pressed = pressed ^ 16'h0200;
    end
    wait_to(64);
    pressed = 16'h0200;
    wait_to(81);
    check_eq("t3_bounce", 32'(strobe_cnt - base), 32'd0);
    wait_to(130);
    check_eq("t3_count", 32'(strobe_cnt - base), 32'd1);
    check_eq("t3_code",  32'(last_code),         32'h9);
    check_eq("t3_held",  32'(key_held),          32'h1);

    // Two keys (0 and F) together, then F released
    base = strobe_cnt;
    start_run(16'h8001);
    release_rst();
    wait_to(96);
    check_eq("t4_multi", 32'(strobe_cnt - base), 32'd0);
    check_eq("t4_held0", 32'(key_held),          32'h0);
    pressed = 16'h0001;
    wait_to(160);
    check_eq("t4_count", 32'(strobe_cnt - base), 32'd1);
    check_eq("t4_code",  32'(last_code),         32'h0);
    check_eq("t4_held",  32'(key_held),          32'h1);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Key A held for 10 frames after acceptance, repeat every 2 frames
    base = strobe_cnt;
    start_run(16'h0400);
    release_rst();
    wait_to(60);
    check_eq("t6_first", 32'(strobe_cnt - base), 32'd1);
    check_eq("t6_code1", 32'(last_code),         32'hA);
    wait_to(215);
    check_eq("t6_repeats", 32'(strobe_cnt - base), 32'd6);
    pressed = 16'h0000;
    wait_to(300);
    check_eq("t6_after", 32'(strobe_cnt - base), 32'd6);
    check_eq("t6_code",  32'(last_code),         32'hA);
    check_eq("t6_held",  32'(key_held),          32'h0);
`endif

    check_eq("kv_back_to_back", 32'(dbl_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
